// File: rtl/instr_rom_ld.sv
`default_nettype none
// ============================================================================
// Module   : instr_rom_ld
// Purpose  : Loadable instruction memory for the fetch stage. A program is
//            streamed in from word 0 through the load port. The fetch port
//            returns the word at a byte-addressed PC one cycle after a
//            req/ack handshake is accepted. Misaligned, out-of-range and
//            past-end-of-program fetches return NOP_INSTR and flag an error.
// Ports    : sys_clk, sys_rst         clock / synchronous active-high reset
//            load_start               pulse: restart loading at word 0
//            load_valid/data/last     load beat stream
//            load_count, load_ovf     words stored / sticky overflow
//            mem_ready                memory is serving fetches
//            fetch_req, fetch_pc      fetch request (held until acked)
//            fetch_ack/instr/err      registered fetch response
// Revision : 1.0 - initial release
// ============================================================================
module instr_rom_ld #(
  parameter int                   PC_W      = 30,
  parameter int                   INSTR_W   = 16,
  parameter int                   DEPTH     = 64,
  parameter int                   ADDR_W    = $clog2(DEPTH),
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                load_start,
  input  logic                load_valid,
  input  logic [INSTR_W-1:0]  load_data,
  input  logic                load_last,
  output logic [ADDR_W:0]     load_count,
  output logic                load_ovf,
  output logic                mem_ready,
  input  logic                fetch_req,
  input  logic [PC_W-1:0]     fetch_pc,
  output logic                fetch_ack,
  output logic [INSTR_W-1:0]  fetch_instr,
  output logic                fetch_err
);

  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t               r_state;
  logic [ADDR_W:0]      r_count;
  logic                 r_ovf;
  logic                 r_ack;
  logic [INSTR_W-1:0]   r_instr;
  logic                 r_err;
  logic [INSTR_W-1:0]   r_mem [DEPTH];

  logic [ADDR_W-1:0]    w_idx;
  logic                 w_misalign;
  logic                 w_beyond;
  logic                 w_past_end;
  logic                 w_err;
  logic                 w_room;
  logic                 w_mem_we;
  logic [INSTR_W-1:0]   w_rd;

  // Upper PC bits are checked separately, so the index slice alone is safe
  // for addressing the array.
  assign w_idx      = fetch_pc[ADDR_W:1];
  assign w_misalign = fetch_pc[0];
  assign w_beyond   = |fetch_pc[PC_W-1:ADDR_W+1];
  assign w_past_end = ({1'b0, w_idx} >= r_count);
  assign w_err      = w_misalign | w_beyond | w_past_end;
  assign w_rd       = r_mem[w_idx];

  assign w_room     = (r_count < c_DEPTH);
  // A beat coinciding with load_start is dropped; reset also blocks writes.
  assign w_mem_we   = !sys_rst && !load_start && (r_state == S_LOAD) &&
                      load_valid && w_room;

  // Memory contents are intentionally not reset.
  always_ff @(posedge sys_clk) begin
    if (w_mem_we) begin
      r_mem[r_count[ADDR_W-1:0]] <= load_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= S_EMPTY;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_ack   <= 1'b0;
      r_instr <= '0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (load_start) begin
        r_state <= S_LOAD;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD: begin
            if (load_valid) begin
              if (w_room) begin
                r_count <= r_count + 1'b1;
              end else begin
                r_ovf <= 1'b1;
              end
              if (load_last) begin
                r_state <= S_READY;
              end
            end
          end
          S_READY: begin
            if (fetch_req) begin
              r_ack <= 1'b1;
              if (w_err) begin
                r_instr <= NOP_INSTR;
                r_err   <= 1'b1;
              end else begin
                r_instr <= w_rd;
                r_err   <= 1'b0;
              end
            end
          end
          S_EMPTY: begin
            r_state <= S_EMPTY;
          end
          default: begin
            r_state <= S_EMPTY;
          end
        endcase
      end
    end
  end

  assign load_count  = r_count;
  assign load_ovf    = r_ovf;
  assign mem_ready   = (r_state == S_READY);
  assign fetch_ack   = r_ack;
  assign fetch_instr = r_instr;
  assign fetch_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_rom_ld.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_rom_ld
// Purpose  : Self-checking bench for instr_rom_ld. Directed vector table,
//            hand-written corner sequences, and randomized loads/fetches
//            compared against a behavioural memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_rom_ld;

  localparam int PC_W    = 30;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 64;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam logic [INSTR_W-1:0] NOP = 16'h0000;

  logic                sys_clk = 1'b0;
  logic                sys_rst;
  logic                load_start, load_valid, load_last;
  logic [INSTR_W-1:0]  load_data;
  logic [ADDR_W:0]     load_count;
  logic                load_ovf, mem_ready;
  logic                fetch_req;
  logic [PC_W-1:0]     fetch_pc;
  logic                fetch_ack, fetch_err;
  logic [INSTR_W-1:0]  fetch_instr;

  instr_rom_ld #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .NOP_INSTR(NOP)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last),
    .load_count(load_count), .load_ovf(load_ovf), .mem_ready(mem_ready),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .fetch_ack(fetch_ack), .fetch_instr(fetch_instr), .fetch_err(fetch_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the memory as seen by the fetch port.
  logic [INSTR_W-1:0] m_mem [DEPTH];
  int                 m_count = 0;
  bit                 m_ovf   = 0;
  bit                 m_ready = 0;

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               err;
  } vec_t;
  vec_t vt [11];

  logic [INSTR_W-1:0] prog7 [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Expected response from the rules: odd PC, or word index not below the
  // number of stored words, is an error (stored count never exceeds DEPTH).
  function automatic logic [INSTR_W:0] model_fetch(input logic [PC_W-1:0] pc);
    longint unsigned widx;
    widx = longint'(pc) / 2;
    if ((pc % 2) == 1 || widx >= longint'(m_count))
      return {1'b1, NOP};
    return {1'b0, m_mem[widx]};
  endfunction

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    m_count = 0; m_ovf = 0; m_ready = 0;
  endtask

  task automatic beat(input logic [INSTR_W-1:0] d, input bit last, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) tick();
    end
    load_valid = 1'b1; load_data = d; load_last = last;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    if (m_count < DEPTH) begin
      m_mem[m_count] = d;
      m_count++;
    end else begin
      m_ovf = 1;
    end
    if (last) m_ready = 1;
  endtask

  // Hold a request until acked (bounded) and compare with the model.
  task automatic fetch_expect(input string name, input logic [PC_W-1:0] pc);
    logic [INSTR_W:0] e;
    bit got;
    e = model_fetch(pc);
    got = 0;
    fetch_req = 1'b1; fetch_pc = pc;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (fetch_ack) got = 1;
    end
    fetch_req = 1'b0;
    chk({name, "_ack"}, 32'(got), 32'd1);
    if (got) begin
      chk({name, "_instr"}, 32'(fetch_instr), 32'(e[INSTR_W-1:0]));
      chk({name, "_err"}, 32'(fetch_err), 32'(e[INSTR_W]));
    end
  endtask

  task automatic expect_stall(input string name, input logic [PC_W-1:0] pc, input int cycles);
    int acks;
    acks = 0;
    fetch_req = 1'b1; fetch_pc = pc;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (fetch_ack) acks++;
    end
    fetch_req = 1'b0;
    chk(name, 32'(acks), 32'd0);
  endtask

  function automatic logic [PC_W-1:0] rand_pc();
    case ($urandom_range(0, 3))
      0: return PC_W'(2 * $urandom_range(0, (m_count > 0) ? m_count - 1 : 0));
      1: return PC_W'(2 * $urandom_range(0, DEPTH - 1) + 1);
      2: return PC_W'(2 * $urandom_range(0, 2 * DEPTH - 1));
      default: return PC_W'($urandom());
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    sys_rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_data = '0; fetch_req = 1'b0; fetch_pc = '0;
    prog7 = '{16'h5CCD, 16'h1A2B, 16'h3C4D, 16'h7E8F, 16'h9A01, 16'hD2E3, 16'hB80E};

    // ---------------- reset state ----------------
    repeat (2) tick();
    sys_rst = 1'b0;
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_load_count", 32'(load_count), 32'd0);
    chk("rst_load_ovf", 32'(load_ovf), 32'd0);
    chk("rst_ack", 32'(fetch_ack), 32'd0);
    chk("rst_instr", 32'(fetch_instr), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    expect_stall("empty_stall", '0, 10);
    chk("empty_mem_ready", 32'(mem_ready), 32'd0);

    // ---------------- 7-word load + vector table ----------------
    start_load();
    for (int i = 0; i < 7; i++) beat(prog7[i], i == 6, 0);
    chk("load7_count", 32'(load_count), 32'd7);
    chk("load7_ready", 32'(mem_ready), 32'd1);
    chk("load7_ovf", 32'(load_ovf), 32'd0);

    for (int i = 0; i < 7; i++) vt[i] = '{PC_W'(2 * i), prog7[i], 1'b0};
    vt[7]  = '{PC_W'('h3),  NOP, 1'b1};
    vt[8]  = '{PC_W'('hE),  NOP, 1'b1};
    vt[9]  = '{PC_W'('h80), NOP, 1'b1};
    vt[10] = '{PC_W'('h3FFF_0000), NOP, 1'b1};

    // Held request, new PC each cycle: one ack per cycle expected.
    for (int i = 0; i < 11; i++) begin
      fetch_req = 1'b1; fetch_pc = vt[i].pc;
      tick();
      chk($sformatf("vec%0d_ack", i), 32'(fetch_ack), 32'd1);
      chk($sformatf("vec%0d_instr", i), 32'(fetch_instr), 32'(vt[i].instr));
      chk($sformatf("vec%0d_err", i), 32'(fetch_err), 32'(vt[i].err));
    end
    fetch_req = 1'b0;
    tick();
    chk("ack_one_cycle", 32'(fetch_ack), 32'd0);
    chk("hold_err", 32'(fetch_err), 32'd1);

    // ---------------- overflow load ----------------
    start_load();
    for (int i = 0; i < DEPTH + 2; i++) beat(16'($urandom()), i == DEPTH + 1, 0);
    chk("ovf_flag", 32'(load_ovf), 32'd1);
    chk("ovf_count", 32'(load_count), 32'(DEPTH));
    chk("ovf_ready", 32'(mem_ready), 32'd1);
    fetch_expect("ovf_last_word", PC_W'(2 * (DEPTH - 1)));
    fetch_expect("ovf_beyond", PC_W'(2 * DEPTH));

    // ---------------- load_start together with fetch_req ----------------
    fetch_req = 1'b1; fetch_pc = '0; load_start = 1'b1;
    tick();
    load_start = 1'b0; fetch_req = 1'b0;
    m_count = 0; m_ovf = 0; m_ready = 0;
    chk("ls_no_ack", 32'(fetch_ack), 32'd0);
    chk("ls_not_ready", 32'(mem_ready), 32'd0);
    chk("ls_ovf_clr", 32'(load_ovf), 32'd0);
    beat(16'hA5A5, 0, 0);
    beat(16'h5A5A, 1, 0);
    fetch_expect("new_w1", PC_W'(2));
    chk("new_w1_val", 32'(fetch_instr), 32'h5A5A);
    fetch_expect("new_past", PC_W'(4));

    // ---------------- reset mid-load ----------------
    start_load();
    for (int i = 0; i < 3; i++) beat(16'($urandom()), 0, 0);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    m_count = 0; m_ready = 0; m_ovf = 0;
    chk("rstld_count", 32'(load_count), 32'd0);
    chk("rstld_ready", 32'(mem_ready), 32'd0);
    expect_stall("rstld_stall", '0, 10);
    start_load();
    beat(16'hC0DE, 1, 0);
    fetch_expect("rstld_w0", '0);
    chk("rstld_w0_val", 32'(fetch_instr), 32'hC0DE);

    // ---------------- randomized loads and fetches ----------------
    for (int r = 0; r < 4; r++) begin
      int len;
      len = (r == 0) ? DEPTH : $urandom_range(1, DEPTH + 3);
      start_load();
      for (int i = 0; i < len; i++) beat(16'($urandom()), i == len - 1, 1);
      chk($sformatf("rnd%0d_count", r), 32'(load_count), 32'(m_count));
      chk($sformatf("rnd%0d_ovf", r), 32'(load_ovf), 32'(m_ovf));
      chk($sformatf("rnd%0d_ready", r), 32'(mem_ready), 32'(m_ready));
      for (int k = 0; k < 25; k++) fetch_expect($sformatf("rnd%0d_f%0d", r, k), rand_pc());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_rom_ld.md
# instr_rom_ld

Parametrised, loadable instruction memory for the core's fetch stage. It holds DEPTH words of INSTR_W bits each. A sequential load port streams a program in from address 0. A fetch port returns the word at a byte-addressed PC with one cycle of latency through a req/ack handshake. Fetches stall until a program has been loaded. Misaligned, out-of-range and past-end-of-program fetches return NOP_INSTR and raise an error flag.

## Interface
- PC_W, 30: fetch PC width (byte address).
- INSTR_W, 16: instruction width; PC step is 2 bytes.
- DEPTH, 64: memory depth in words; power of two, at least 2.
- ADDR_W, $clog2(DEPTH): word address width (derived).
- NOP_INSTR, 16'h0000: word returned on an error fetch.

Ports:
- sys_clk  in  1  clock; all logic on posedge.
- sys_rst  in  1  synchronous, active-high reset.
- load_start  in  1  one-cycle pulse: begin a new load at word 0.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  INSTR_W  program word.
- load_last  in  1  qualifies the final beat of a load (with load_valid).
- load_count  out  ADDR_W+1  number of words stored by the current or last load.
- load_ovf  out  1  sticky: a beat arrived while load_count == DEPTH.
- mem_ready  out  1  state == READY.
- fetch_req  in  1  fetch request; held until acked.
- fetch_pc  in  PC_W  byte PC of the request.
- fetch_ack  out  1  one-cycle pulse: fetch_instr/fetch_err valid.
- fetch_instr  out  INSTR_W  fetched word.
- fetch_err  out  1  fetch was misaligned, out of range, or past the loaded count.

## Operation
- FSM states:
  - EMPTY: reset state.
  - LOAD: a load is in progress.
  - READY: fetches are served.
- Transitions:
  - load_start in any state → LOAD, with load_count ← 0 and load_ovf ← 0.
  - LOAD with load_valid && load_last → READY.
  - No other transitions.
- A load_start that arrives together with a load_valid beat drops that beat.
- Load beat in LOAD with load_valid:
  - If load_count < DEPTH: mem[load_count] ← load_data, load_count++.
  - Otherwise: drop the data and set load_ovf.
  - load_last ends the load in both cases, including a load_last beat that overflows.
- A zero-length load is not possible; a load ends only on a valid beat.
- Fetch acceptance: state == READY && fetch_req && !load_start. Not accepted in EMPTY or LOAD, or while load_start is high; the requester holds fetch_req and fetch_pc until acked.
- Word index = fetch_pc >> 1. The fetch is an error if any of these hold:
  - fetch_pc[0] == 1 (misaligned);
  - fetch_pc[PC_W-1:ADDR_W+1] ≠ 0 (beyond DEPTH);
  - word index ≥ load_count (past the loaded program).
- On error: fetch_instr = NOP_INSTR, fetch_err = 1. Otherwise: fetch_instr = mem[index], fetch_err = 0.
- Memory array is not cleared by sys_rst; contents persist, but after reset every fetch stalls until a new load completes.
- Reset values: state EMPTY, load_count 0, load_ovf 0, mem_ready 0, fetch_ack 0, fetch_instr 0, fetch_err 0.

## Timing
- Fetch latency 1: accepted at edge N, so fetch_ack, fetch_instr and fetch_err are registered and valid for the cycle after edge N.
- fetch_ack is high for exactly one cycle per accepted fetch.
- Back-to-back fetches: fetch_req held high with a new fetch_pc each cycle gives one ack per cycle (full throughput).
- fetch_instr and fetch_err hold their last value while fetch_ack = 0.
- A load beat written at edge N is readable by a fetch accepted at edge N+1 or later.
- mem_ready rises the cycle after the load_last beat's edge. It falls the cycle after load_start.
- A fetch accepted on the cycle before load_start still completes; its ack arrives in the load_start cycle with pre-load contents.
- sys_rst takes priority over everything:
  - Asserted mid-load, it abandons the load (state EMPTY, load_count 0).
  - Asserted in the cycle after an accepted fetch, it forces fetch_ack to 0 at the next edge, so that ack is lost.

## Test plan
- Reset, then fetch_req with pc 0x0 → no fetch_ack for 10 cycles; mem_ready = 0.
- Load 7 words (0x5CCD, …, 0xB80E), load_last on word 7, then fetch pc 0x0, 0x2, …, 0xC back-to-back → 7 consecutive acks returning the loaded words in order, fetch_err = 0, load_count = 7.
- After that load:
  - pc 0x3 → ack, NOP_INSTR, err = 1.
  - pc 0xE → err = 1 (past count).
  - pc 0x80 with DEPTH 64 → err = 1 (beyond DEPTH).
- Load DEPTH+2 words with load_last on the last → load_ovf = 1, load_count = DEPTH, state READY, last stored word = beat DEPTH.
- In READY, assert load_start together with fetch_req → no ack for that request; mem_ready = 0 the next cycle. Load 2 new words, then fetch pc 0x2 → new word 1; pc 0x4 → err = 1.
- Assert sys_rst mid-load after 3 beats → load_count = 0, state EMPTY, fetches stall. After a new 1-word load, pc 0x0 returns the new word.
